// File: rtl/serial_adder.sv
// Bit-serial (CHUNK bits per clock) adder/subtractor with registered sum, carry-out
// and two's-complement overflow. LSB chunk is processed first.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic [1:0]       state_dbg
);

    localparam int NCYC = WIDTH / CHUNK;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_cmsb;
    logic             last_chunk;

    // Ripple over the low CHUNK bits of the shifting operand registers. chunk_cmsb is
    // the carry into the top bit of the chunk, which on the last chunk is the word MSB.
    always_comb begin : chunk_add
        logic c;
        c          = carry_q;
        chunk_sum  = '0;
        chunk_cmsb = carry_q;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_cmsb   = c;
            chunk_sum[i] = a_q[i] ^ b_q[i] ^ c;
            c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        chunk_cout = c;
    end

    assign last_chunk = (cnt_q == CW'(NCYC - 1));

    // start is a request sampled only in IDLE or DONE; there is no ready output, the
    // caller uses busy to know that a start asserted during RUN is dropped.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                acc_d   = (acc_q >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));
                carry_d = chunk_cout;
                cnt_d   = cnt_q + CW'(1);
                if (last_chunk) begin
                    cnt_d   = '0;
                    sum_d   = acc_d;
                    c_out_d = chunk_cout;
                    ovf_d   = chunk_cout ^ chunk_cmsb;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign overflow  = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit CHUNK=1 and CHUNK=4 instances plus three
// 4-bit instances (CHUNK 1, 2, 4) swept over every operand combination.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [9:0] prev8 = '0;
    logic [5:0] exp_q[$];

    // 8-bit, CHUNK=1
    logic       p_start, p_cin, p_sub, p_busy, p_done, p_cout, p_ovf;
    logic [7:0] p_a, p_b, p_sum;
    logic [1:0] p_st;
    // 8-bit, CHUNK=4
    logic       q_start, q_cin, q_sub, q_busy, q_done, q_cout, q_ovf;
    logic [7:0] q_a, q_b, q_sum;
    logic [1:0] q_st;
    // 4-bit trio, shared inputs
    logic       t_start, t_cin, t_sub;
    logic [3:0] t_a, t_b;
    logic       r1_busy, r1_done, r1_cout, r1_ovf;
    logic       r2_busy, r2_done, r2_cout, r2_ovf;
    logic       r4_busy, r4_done, r4_cout, r4_ovf;
    logic [3:0] r1_sum, r2_sum, r4_sum;
    logic [1:0] r1_st, r2_st, r4_st;

    serial_adder #(.WIDTH(8), .CHUNK(1)) u_p (
        .clk(clk), .rst_n(rst_n), .start(p_start), .a(p_a), .b(p_b), .c_in(p_cin), .sub(p_sub),
        .busy(p_busy), .done(p_done), .sum(p_sum), .c_out(p_cout), .overflow(p_ovf), .state_dbg(p_st)
    );
    serial_adder #(.WIDTH(8), .CHUNK(4)) u_q (
        .clk(clk), .rst_n(rst_n), .start(q_start), .a(q_a), .b(q_b), .c_in(q_cin), .sub(q_sub),
        .busy(q_busy), .done(q_done), .sum(q_sum), .c_out(q_cout), .overflow(q_ovf), .state_dbg(q_st)
    );
    serial_adder #(.WIDTH(4), .CHUNK(1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .start(t_start), .a(t_a), .b(t_b), .c_in(t_cin), .sub(t_sub),
        .busy(r1_busy), .done(r1_done), .sum(r1_sum), .c_out(r1_cout), .overflow(r1_ovf), .state_dbg(r1_st)
    );
    serial_adder #(.WIDTH(4), .CHUNK(2)) u_r2 (
        .clk(clk), .rst_n(rst_n), .start(t_start), .a(t_a), .b(t_b), .c_in(t_cin), .sub(t_sub),
        .busy(r2_busy), .done(r2_done), .sum(r2_sum), .c_out(r2_cout), .overflow(r2_ovf), .state_dbg(r2_st)
    );
    serial_adder #(.WIDTH(4), .CHUNK(4)) u_r4 (
        .clk(clk), .rst_n(rst_n), .start(t_start), .a(t_a), .b(t_b), .c_in(t_cin), .sub(t_sub),
        .busy(r4_busy), .done(r4_done), .sum(r4_sum), .c_out(r4_cout), .overflow(r4_ovf), .state_dbg(r4_st)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One operation on the CHUNK=1 instance; a stray start with scrambled operands is
    // injected mid-run and the held result is checked while the run is in progress.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub,
                       input logic [7:0] esum, input logic ecout, input logic eovf);
        int cyc;
        int nbusy;
        p_a = a; p_b = b; p_cin = cin; p_sub = sub; p_start = 1'b1;
        @(negedge clk);
        p_start = 1'b0;
        cyc = 1;
        nbusy = 0;
        while (!p_done && cyc < 40) begin
            nbusy += int'(p_busy);
            if (cyc == 3) begin
                p_start = 1'b1; p_a = ~a; p_b = a ^ b; p_cin = ~cin; p_sub = ~sub;
            end
            if (cyc == 4) begin
                p_start = 1'b0;
                check_eq({tag, "_hold"}, 32'({p_cout, p_ovf, p_sum}), 32'(prev8));
            end
            @(negedge clk);
            cyc++;
        end
        p_start = 1'b0;
        check_eq({tag, "_lat"}, cyc, 9);
        check_eq({tag, "_busy"}, nbusy, 8);
        check_eq({tag, "_res"}, 32'({p_cout, p_ovf, p_sum}), 32'({ecout, eovf, esum}));
        prev8 = {ecout, eovf, esum};
        @(negedge clk);
        check_eq({tag, "_idle"}, 32'({p_busy, p_done}), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b2b_sum[3];
        int         seen;
        b2b_sum[0] = 8'h30; b2b_sum[1] = 8'h77; b2b_sum[2] = 8'h03;
        p_start = 0; p_a = 0; p_b = 0; p_cin = 0; p_sub = 0;
        q_start = 0; q_a = 0; q_b = 0; q_cin = 0; q_sub = 0;
        t_start = 0; t_a = 0; t_b = 0; t_cin = 0; t_sub = 0;

        repeat (2) @(negedge clk);
        check_eq("rst_p",  32'({p_busy, p_done, p_cout, p_ovf, p_sum, p_st}), 0);
        check_eq("rst_q",  32'({q_busy, q_done, q_cout, q_ovf, q_sum, q_st}), 0);
        check_eq("rst_r1", 32'({r1_busy, r1_done, r1_cout, r1_ovf, r1_sum, r1_st}), 0);
        check_eq("rst_r2", 32'({r2_busy, r2_done, r2_cout, r2_ovf, r2_sum, r2_st}), 0);
        check_eq("rst_r4", 32'({r4_busy, r4_done, r4_cout, r4_ovf, r4_sum, r4_st}), 0);
        rst_n = 1'b1;

        op8("ff_p_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("7f_p_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("80_p_ff", 8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1);
        op8("05_m_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("80_m_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Back-to-back on CHUNK=4: start held high; operand change mid-run must be ignored.
        q_a = 8'h10; q_b = 8'h20; q_start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            logic edone, ebusy;
            @(negedge clk);
            edone = (c % 3 == 0) && (c <= 9);
            ebusy = !edone && (c <= 8);
            check_eq($sformatf("b2b_bd_c%0d", c), 32'({q_busy, q_done}), 32'({ebusy, edone}));
            if (edone)
                check_eq($sformatf("b2b_sum_c%0d", c), 32'(q_sum), 32'(b2b_sum[c / 3 - 1]));
            if (c == 1) begin q_a = 8'h33; q_b = 8'h44; end
            if (c == 6) begin q_a = 8'h01; q_b = 8'h02; end
            if (c == 9) q_start = 1'b0;
        end

        // Asynchronous reset in the middle of a run.
        p_a = 8'h11; p_b = 8'h22; p_cin = 0; p_sub = 0; p_start = 1'b1;
        @(negedge clk);
        p_start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_p", 32'({p_busy, p_done, p_cout, p_ovf, p_sum, p_st}), 0);
        check_eq("arst_q", 32'({q_busy, q_done, q_cout, q_ovf, q_sum, q_st}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        prev8 = '0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            seen += int'(p_done);
        end
        check_eq("arst_nodone", seen, 0);
        op8("12_p_34", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

        // Exhaustive 4-bit sweep against a behavioural model.
        for (int sb = 0; sb < 2; sb++) begin
            for (int ci = 0; ci < 2; ci++) begin
                for (int ai = 0; ai < 16; ai++) begin
                    for (int bi = 0; bi < 16; bi++) begin
                        logic [3:0] av, be;
                        logic [4:0] full;
                        logic       ov;
                        logic [5:0] e;
                        string      tg;
                        av = ai[3:0];
                        be = sb[0] ? ~bi[3:0] : bi[3:0];
                        full = {1'b0, av} + {1'b0, be} + 5'(ci);
                        ov = (av[3] == be[3]) && (full[3] != av[3]);
                        exp_q.push_back({full[4], ov, full[3:0]});
                        t_a = ai[3:0]; t_b = bi[3:0]; t_cin = ci[0]; t_sub = sb[0];
                        t_start = 1'b1;
                        @(negedge clk);
                        t_start = 1'b0;
                        repeat (5) @(negedge clk);
                        e = exp_q.pop_front();
                        tg = $sformatf("a%0h_b%0h_c%0d_s%0d", ai, bi, ci, sb);
                        check_eq({"sw1_", tg}, 32'({r1_cout, r1_ovf, r1_sum}), 32'(e));
                        check_eq({"sw2_", tg}, 32'({r2_cout, r2_ovf, r2_sum}), 32'(e));
                        check_eq({"sw4_", tg}, 32'({r4_cout, r4_ovf, r4_sum}), 32'(e));
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
